// File: rtl/inputs_mem_burst.sv
// Input-operand memory: registered single-word reads and a burst engine that
// streams consecutive words (wrapping at DEPTH) with valid and done strobes.
module inputs_mem_burst #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in,
    input  logic [ADDR_W-1:0] address,
    input  logic              write,
    input  logic              read,
    input  logic              burst_start,
    input  logic [ADDR_W-1:0] burst_base,
    input  logic [ADDR_W:0]   burst_len,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned LEN_W = ADDR_W + 1;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] ptr, ptr_nx;
    logic [ADDR_W-1:0] rd_addr;
    logic [LEN_W-1:0]  remaining, remaining_nx;
    logic              rd_en;
    logic              out_valid_nx;
    logic              busy_nx;
    logic              done_nx;
    logic              start_ok;

    // A zero-length request is treated as if no start was seen.
    assign start_ok = burst_start && (burst_len != '0);

    // Next-state, burst bookkeeping and next values of the registered outputs.
    always_comb begin
        state_nx     = state;
        ptr_nx       = ptr;
        remaining_nx = remaining;
        rd_en        = 1'b0;
        rd_addr      = address;
        out_valid_nx = 1'b0;
        busy_nx      = 1'b0;
        done_nx      = 1'b0;

        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nx     = STREAM;
                    ptr_nx       = burst_base;
                    remaining_nx = burst_len;
                    busy_nx      = 1'b1;
                end else if (read) begin
                    rd_en        = 1'b1;
                    out_valid_nx = 1'b1;
                end
            end
            STREAM: begin
                rd_en        = 1'b1;
                rd_addr      = ptr;
                out_valid_nx = 1'b1;
                // busy stays up through the last word's cycle
                busy_nx      = 1'b1;
                ptr_nx       = ptr + ADDR_W'(1);
                remaining_nx = remaining - LEN_W'(1);
                if (remaining == LEN_W'(1)) begin
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, memory and output registers; reads see pre-write contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            mem       <= '{default: '0};
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            remaining <= remaining_nx;
            if (write) begin
                mem[address] <= in;
            end
            if (rd_en) begin
                out <= mem[rd_addr];
            end
            out_valid <= out_valid_nx;
            busy      <= busy_nx;
            done      <= done_nx;
        end
    end

endmodule

// File: tb/tb_inputs_mem_burst.sv
// Scoreboard bench for inputs_mem_burst: expected words are queued when a read
// or burst is driven and compared as out_valid words appear.
module tb_inputs_mem_burst;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DEPTH  = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] in;
    logic [ADDR_W-1:0] address;
    logic              write;
    logic              read;
    logic              burst_start;
    logic [ADDR_W-1:0] burst_base;
    logic [ADDR_W:0]   burst_len;
    logic [DATA_W-1:0] out;
    logic              out_valid;
    logic              busy;
    logic              done;

    inputs_mem_burst #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in          (in),
        .address     (address),
        .write       (write),
        .read        (read),
        .burst_start (burst_start),
        .burst_base  (burst_base),
        .burst_len   (burst_len),
        .out         (out),
        .out_valid   (out_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] model [DEPTH];
    logic              mon_en = 1'b0;
    int                total  = 0;
    int                bad    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    // Output monitor, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 32'(out_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("word", 32'(out), 32'(e.data));
                    check("done_flag", 32'(done), 32'(e.last));
                end
            end else begin
                check("done_wo_valid", 32'(done), 32'd0);
            end
        end
    end

    task automatic idle();
        write       = 1'b0;
        read        = 1'b0;
        burst_start = 1'b0;
    endtask

    task automatic nop(input int n);
        repeat (n) begin
            @(negedge clk);
            idle();
        end
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        idle();
        write   = 1'b1;
        address = a;
        in      = d;
        model[a] = d;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a);
        exp_t e;
        @(negedge clk);
        idle();
        read    = 1'b1;
        address = a;
        e.data  = model[a];
        e.last  = 1'b0;
        exp_q.push_back(e);
    endtask

    // Same-edge write and read: the read returns the old content.
    task automatic do_wr_rd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        do_read(a);
        write    = 1'b1;
        in       = d;
        model[a] = d;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        idle();
        mon_en = 1'b0;
        rst    = 1'b1;
        repeat (n) @(negedge clk);
        check("rst_out", 32'(out), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
        exp_q.delete();
        mon_en = 1'b1;
    endtask

    // Burst with optional mid-burst write (issued in the first stream cycle)
    // and optional ignored read/start noise during STREAM.
    task automatic do_burst(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len,
                            input bit mid_wr, input logic [ADDR_W-1:0] wr_a,
                            input logic [DATA_W-1:0] wr_d, input bit noise);
        logic [ADDR_W-1:0] p;
        exp_t              e;
        p = base;
        @(negedge clk);
        idle();
        burst_start = 1'b1;
        burst_base  = base;
        burst_len   = len;
        for (int j = 0; j < int'(len); j++) begin
            @(negedge clk);
            idle();
            if (j == 0) check("busy_start", 32'(busy), 32'd1);
            e.data = model[p];
            e.last = (j == int'(len) - 1);
            exp_q.push_back(e);
            p = p + ADDR_W'(1);
            if (noise) begin
                read        = 1'b1;
                address     = ADDR_W'(j);
                burst_start = 1'b1;
                burst_base  = ADDR_W'(j + 3);
                burst_len   = 8'd2;
            end
            if (mid_wr && j == 0) begin
                write       = 1'b1;
                address     = wr_a;
                in          = wr_d;
                model[wr_a] = wr_d;
            end
        end
        @(negedge clk);
        idle();
        check("busy_last", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        in          = '0;
        address     = '0;
        burst_base  = '0;
        burst_len   = '0;
        idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset after arbitrary writes clears memory.
        do_write(7'd0, 16'hbeef);
        do_write(7'd127, 16'h1234);
        do_reset(4);
        do_read(7'd0);
        do_read(7'd127);

        // Single write/read, with out holding between reads.
        do_write(7'd0, 16'd4);
        do_read(7'd3);
        do_read(7'd0);
        nop(2);
        check("out_hold", 32'(out), 32'd4);
        check("valid_hold", 32'(out_valid), 32'd0);

        // Read-before-write collision.
        do_wr_rd(7'd9, 16'd55);
        do_read(7'd9);

        // Fill and burst across the wrap point.
        for (int i = 0; i < int'(DEPTH); i++) do_write(ADDR_W'(i), DATA_W'(i + 100));
        nop(1);
        check("fill_spot", 32'(model[126]), 32'd226);
        do_burst(7'd126, 8'd4, 1'b0, '0, '0, 1'b0);

        // Write to a not-yet-streamed address during a burst.
        do_burst(7'd20, 8'd5, 1'b1, 7'd22, 16'd999, 1'b0);

        // Zero-length start with a concurrent read.
        @(negedge clk);
        idle();
        burst_start = 1'b1;
        burst_len   = 8'd0;
        burst_base  = 7'd50;
        begin
            exp_t e;
            read    = 1'b1;
            address = 7'd5;
            e.data  = model[5];
            e.last  = 1'b0;
            exp_q.push_back(e);
        end
        @(negedge clk);
        idle();
        check("len0_busy", 32'(busy), 32'd0);

        // Requests during STREAM are ignored.
        do_burst(7'd40, 8'd6, 1'b0, '0, '0, 1'b1);
        do_burst(7'd60, 8'd1, 1'b0, '0, '0, 1'b0);

        // Reset during word 2 of a len=8 burst.
        @(negedge clk);
        idle();
        burst_start = 1'b1;
        burst_base  = 7'd10;
        burst_len   = 8'd8;
        for (int j = 0; j < 2; j++) begin
            exp_t e;
            @(negedge clk);
            idle();
            e.data = model[10 + j];
            e.last = 1'b0;
            exp_q.push_back(e);
        end
        @(negedge clk);
        idle();
        rst    = 1'b1;
        mon_en = 1'b0;
        @(negedge clk);
        check("abort_out", 32'(out), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_pending", 32'(exp_q.size()), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
        mon_en = 1'b1;

        // Full-depth burst after reset: every word reads zero.
        do_burst(7'd0, 8'd128, 1'b0, '0, '0, 1'b0);

        // Full-depth burst with wrap over distinct data.
        for (int i = 0; i < 8; i++) do_write(ADDR_W'(i * 17), DATA_W'(i * 311 + 7));
        do_burst(7'd125, 8'd128, 1'b0, '0, '0, 1'b0);

        nop(3);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inputs_mem_burst.md
# inputs_mem_burst

Parametrised input-operand memory with registered single-word access and a burst streaming engine. It replaces the fixed 128 x 16 input memory in the datapath front end. Software and the loader write operands word by word. The compute core then either reads single words or requests a burst, which streams consecutive words with a valid strobe and a completion pulse. Depth, data width and burst length are generalised through parameters.

## Interface
- DATA_W, 16, word width in bits
- ADDR_W, 7, address width; DEPTH = 2**ADDR_W words (derived, not overridable)

- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in  input  DATA_W  write data
- address  input  ADDR_W  single-access address (write and read)
- write  input  1  write enable, mem[address] <= in
- read  input  1  single-word read request
- burst_start  input  1  start burst, sampled only in IDLE
- burst_base  input  ADDR_W  first burst address
- burst_len  input  ADDR_W+1  burst word count, 1..DEPTH; 0 is ignored
- out  output  DATA_W  registered read data
- out_valid  output  1  out carries a new word this cycle
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse concurrent with the last burst word

## Operation
- Reset (rst=1 at an edge) has priority over all other inputs.
  - Every memory word is cleared to 0.
  - out=0, out_valid=0, busy=0, done=0, state=IDLE.
  - Burst pointer and counter are cleared.
- States: IDLE, STREAM.
- Write behaviour, any state:
  - write=1: mem[address] <= in at the edge.
  - Writes are never blocked.
- IDLE:
  - burst_start=1 and burst_len!=0: latch ptr=burst_base and remaining=burst_len, then go to STREAM. A read in the same cycle is ignored.
  - burst_start=1 and burst_len=0: no effect. Treated as no start; a concurrent read proceeds.
  - read=1 (no accepted start): out <= mem[address], out_valid=1 for one cycle.
  - Otherwise out_valid=0 and out holds its last value.
- STREAM:
  - Each cycle: out <= mem[ptr], out_valid=1, ptr <= ptr+1 mod DEPTH (wraps from DEPTH-1 to 0), remaining <= remaining-1.
  - When remaining=1: done=1 with that word, and the next state is IDLE.
  - read and burst_start are ignored, and busy=1 throughout.
- Read/write collision, same address, same edge (single read or burst word): out returns the old content (read-before-write). The new value is visible from the following cycle.
- A write to a not-yet-streamed address during a burst is returned by the burst.
- Reset mid-burst: the burst aborts with no done pulse, memory is cleared, and IDLE is entered after the edge.

## Timing
- Single read: read sampled at edge k, so out/out_valid are valid after edge k. Latency is 1 cycle.
- Burst: burst_start sampled at edge k, so busy=1 after edge k.
  - The first word is valid after edge k+1.
  - The last word plus done come after edge k+burst_len.
  - busy drops after edge k+burst_len+1, together with out_valid and done.
- Back-to-back bursts:
  - The earliest next burst_start is sampled at edge k+burst_len+1.
  - So there is a minimum 1-cycle out_valid gap between bursts.
- out_valid is 0 in every cycle with no new word. done is never high without out_valid.
- Full-depth burst (burst_len=DEPTH) reads every word exactly once, including the wrap.

## Test plan
- Reset: hold rst 4 cycles after arbitrary writes. Then read addr 0 and 127: out=0, out_valid=1 one cycle after each read, busy=0, done=0.
- Single write/read: write in=4 to address 0. Read address 3, giving out=0. Read address 0, giving out=4. Each result arrives 1 cycle after its request, and out holds between reads.
- Burst with wrap: fill mem[i]=i+100.
  - Start with base=126, len=4.
  - out sequence 226,227,100,101 on consecutive cycles with out_valid=1.
  - done only with 101, and busy low one cycle later.
- Collisions:
  - Same-edge write in=55 and read at address 9 (old value 0): out=0; the next read gives 55.
  - During a burst, write address base+2 before it streams: the burst returns the new value.
- Ignored requests:
  - burst_len=0 with read=1 at address 5: single read occurs, busy stays 0.
  - burst_start and read during STREAM: no effect on the sequence.
- Reset mid-burst:
  - Assert rst during word 2 of a len=8 burst.
  - Next cycle: out=0, out_valid=0, busy=0, no done pulse, all memory reads 0.
  - A new burst then starts normally.
